// File: rtl/log_multiplier_pipe_pkg.sv
// Shared log-domain helpers: fraction / leading-one widths and a leading-one search.
package log_mult_pkg;

    localparam int MAX_W = 64;

    function automatic int frac_bits(input int w);
        return w - 1;
    endfunction

    function automatic int lod_bits(input int w);
        return $clog2(w);
    endfunction

    // Highest set bit index; 0 for an all-zero word (callers gate that with a zero flag).
    function automatic int lead_pos(input logic [MAX_W-1:0] v);
        int pos;
        pos = 0;
        for (int i = 0; i < MAX_W; i++)
            if (v[i]) pos = i;
        return pos;
    endfunction

endpackage

// File: rtl/log_multiplier_pipe_if.sv
// Operand/result handshake bundle for the pipelined log multiplier.
interface log_multiplier_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_zero;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero, busy
    );
endinterface

// File: rtl/log_multiplier_pipe_lod.sv
// Leading-one detector: zero flag, leading-one index and the bits below it left-aligned.
module lod_param
    import log_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int F = frac_bits(WIDTH),
    localparam int K = lod_bits(WIDTH)
) (
    input  logic [WIDTH-1:0] val_i,
    output logic             zero_o,
    output logic [K-1:0]     k_o,
    output logic [F-1:0]     x_o
);
    int pos;

    // Shifting the leading one up to bit F leaves the fraction in the low F bits.
    always_comb begin
        pos    = lead_pos(MAX_W'(val_i));
        zero_o = (val_i == '0);
        k_o    = K'(pos);
        x_o    = F'(val_i << (F - pos));
    end
endmodule

// File: rtl/log_multiplier_pipe.sv
// Three-stage Mitchell log multiplier: LOD -> log-domain add -> antilog shift,
// with a single global stall driven by output back-pressure.
module log_multiplier_pipe
    import log_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    log_multiplier_pipe_if.slave bus
);
    localparam int F      = frac_bits(WIDTH);
    localparam int K      = lod_bits(WIDTH);
    localparam int STAGES = 3;
    localparam int PW     = 3*WIDTH - 1;
    localparam int RW     = 2*WIDTH;

    logic             za_d, zb_d;
    logic [K-1:0]     ka_d, kb_d;
    logic [F-1:0]     xa_d, xb_d;

    lod_param #(.WIDTH(WIDTH)) u_lod_a (.val_i(bus.in_a), .zero_o(za_d), .k_o(ka_d), .x_o(xa_d));
    lod_param #(.WIDTH(WIDTH)) u_lod_b (.val_i(bus.in_b), .zero_o(zb_d), .k_o(kb_d), .x_o(xb_d));

    logic [STAGES:1]  vld_pipe_q;
    logic             stall;

    // stage 1
    logic             za_q, zb_q;
    logic [K-1:0]     ka_q, kb_q;
    logic [F-1:0]     xa_q, xb_q;
    logic [TAG_W-1:0] tag1_q;
    // stage 2
    logic [K:0]       ksum_d, ksum_q;
    logic [F:0]       fsum_d, fsum_q;
    logic             zero2_q;
    logic [TAG_W-1:0] tag2_q;
    // stage 3
    logic [RW-1:0]    result_d, result_q;
    logic             zero3_q;
    logic [TAG_W-1:0] tag3_q;

    logic [K:0]       exp_w;
    logic [WIDTH-1:0] mant;
    logic [PW-1:0]    prod;

    always_comb begin
        ksum_d   = {1'b0, ka_q} + {1'b0, kb_q};
        fsum_d   = {1'b0, xa_q} + {1'b0, xb_q};
        // Fraction carry bumps the exponent; the mantissa keeps only the low F bits.
        exp_w    = ksum_q + {{K{1'b0}}, fsum_q[F]};
        mant     = {1'b1, fsum_q[F-1:0]};
        prod     = PW'(mant) << exp_w;
        result_d = zero2_q ? '0 : RW'(prod >> F);
    end

    assign stall          = vld_pipe_q[STAGES] & ~bus.out_ready;
    assign bus.in_ready   = ~stall;
    assign bus.out_valid  = vld_pipe_q[STAGES];
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag3_q;
    assign bus.out_zero   = zero3_q;
    assign bus.busy       = |vld_pipe_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            za_q       <= 1'b0;
            zb_q       <= 1'b0;
            ka_q       <= '0;
            kb_q       <= '0;
            xa_q       <= '0;
            xb_q       <= '0;
            tag1_q     <= '0;
            ksum_q     <= '0;
            fsum_q     <= '0;
            zero2_q    <= 1'b0;
            tag2_q     <= '0;
            result_q   <= '0;
            zero3_q    <= 1'b0;
            tag3_q     <= '0;
        end else if (!stall) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
            za_q       <= za_d;
            zb_q       <= zb_d;
            ka_q       <= ka_d;
            kb_q       <= kb_d;
            xa_q       <= xa_d;
            xb_q       <= xb_d;
            tag1_q     <= bus.in_tag;
            ksum_q     <= ksum_d;
            fsum_q     <= fsum_d;
            zero2_q    <= za_q | zb_q;
            tag2_q     <= tag1_q;
            result_q   <= result_d;
            zero3_q    <= zero2_q;
            tag3_q     <= tag2_q;
        end
    end
endmodule

// File: tb/tb_log_multiplier_pipe.sv
// Directed and randomised checks of the pipelined Mitchell multiplier at WIDTH=8 and WIDTH=16.
module tb_log_multiplier_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    log_multiplier_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();
    log_multiplier_pipe_if #(.WIDTH(16), .TAG_W(4)) bus16 ();

    log_multiplier_pipe #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
    log_multiplier_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    // Mitchell approximation written from the log/antilog arithmetic.
    function automatic longint model(input longint a, input longint b, input int w);
        int     f, ka, kb, e;
        longint xa, xb, fs, one_f, m;
        f = w - 1;
        if (a == 0 || b == 0) return 0;
        ka = 0;
        while ((longint'(1) << (ka + 1)) <= a) ka++;
        kb = 0;
        while ((longint'(1) << (kb + 1)) <= b) kb++;
        xa    = (a - (longint'(1) << ka)) << (f - ka);
        xb    = (b - (longint'(1) << kb)) << (f - kb);
        one_f = longint'(1) << f;
        fs    = xa + xb;
        e     = ka + kb + ((fs >= one_f) ? 1 : 0);
        m     = one_f + (fs % one_f);
        return (m << e) >> f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        tests++;
        if ({bus8.out_valid, bus8.busy, bus8.in_ready, bus8.out_zero} !== 4'b0010) begin
            fails++;
            $display("FAIL reset_flags: got valid/busy/ready/zero=%b expected 0010",
                     {bus8.out_valid, bus8.busy, bus8.in_ready, bus8.out_zero});
        end
        tests++;
        if (bus8.out_result !== 16'd0 || bus8.out_tag !== 4'd0) begin
            fails++;
            $display("FAIL reset_data: got result=%0d tag=%0d expected 0/0", bus8.out_result, bus8.out_tag);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  va [7] = '{8'd3, 8'd5, 8'd255, 8'd128, 8'd0,   8'd77, 8'd1};
        logic [7:0]  vb [7] = '{8'd3, 8'd6, 8'd255, 8'd2,   8'd200, 8'd0,  8'd1};
        logic [15:0] vr [7] = '{16'd8, 16'd28, 16'd65024, 16'd256, 16'd0, 16'd0, 16'd1};
        logic        vz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in_a     = va[i];
            bus8.in_b     = vb[i];
            bus8.in_tag   = 4'(i + 1);
            step();
            bus8.in_valid = 1'b0;
            step();
            tests++;
            if (bus8.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_early: got out_valid=%b expected 0 after 2 cycles", i, bus8.out_valid);
            end
            step();
            tests++;
            if (bus8.out_valid !== 1'b1 || bus8.out_result !== vr[i] || bus8.out_zero !== vz[i]
                || bus8.out_tag !== 4'(i + 1)) begin
                fails++;
                $display("FAIL vec%0d: got v=%b res=%0d zero=%b tag=%0d expected v=1 res=%0d zero=%b tag=%0d",
                         i, bus8.out_valid, bus8.out_result, bus8.out_zero, bus8.out_tag, vr[i], vz[i], i + 1);
            end
            step();
            tests++;
            if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_drain: got valid=%b busy=%b expected 0/0", i, bus8.out_valid, bus8.busy);
            end
        end
    endtask

    // a = tag+1, b = 3 streamed back-to-back with a 5-cycle consumer stall mid-stream.
    task automatic test_backpressure();
        logic [15:0] exp_r [10] = '{16'd3, 16'd6, 16'd8, 16'd12, 16'd14, 16'd16, 16'd20, 16'd24, 16'd26, 16'd28};
        int          sent = 0;
        int          got = 0;
        int          stall_cycles = 0;
        logic        held = 1'b0;
        logic [15:0] h_res = '0;
        logic [3:0]  h_tag = '0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            bus8.out_ready = (c < 5 || c >= 10);
            bus8.in_valid  = (sent < 10);
            bus8.in_a      = 8'(sent + 1);
            bus8.in_b      = 8'd3;
            bus8.in_tag    = 4'(sent);
            #1;
            if (held) begin
                tests++;
                if (bus8.out_valid !== 1'b1 || bus8.out_result !== h_res || bus8.out_tag !== h_tag) begin
                    fails++;
                    $display("FAIL bp_hold c=%0d: got v=%b res=%0d tag=%0d expected v=1 res=%0d tag=%0d",
                             c, bus8.out_valid, bus8.out_result, bus8.out_tag, h_res, h_tag);
                end
            end
            held = 1'b0;
            if (bus8.out_valid && !bus8.out_ready) begin
                tests++;
                if (bus8.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, bus8.in_ready);
                end
                held = 1'b1;
                h_res = bus8.out_result;
                h_tag = bus8.out_tag;
                stall_cycles++;
            end
            if (bus8.out_valid && bus8.out_ready) begin
                tests++;
                if (bus8.out_tag !== 4'(got) || bus8.out_result !== exp_r[got]) begin
                    fails++;
                    $display("FAIL bp_result%0d: got res=%0d tag=%0d expected res=%0d tag=%0d",
                             got, bus8.out_result, bus8.out_tag, exp_r[got], got);
                end
                got++;
            end
            if (bus8.in_valid && bus8.in_ready) sent++;
            step();
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        tests++;
        if (got != 10 || stall_cycles != 5) begin
            fails++;
            $display("FAIL bp_count: got delivered=%0d stall_cycles=%0d expected 10/5", got, stall_cycles);
        end
    endtask

    task automatic test_width16();
        bus16.out_ready = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.in_a      = 16'hFFFF;
        bus16.in_b      = 16'hFFFF;
        bus16.in_tag    = 4'hA;
        step();
        bus16.in_valid = 1'b0;
        step();
        step();
        tests++;
        if (bus16.out_valid !== 1'b1 || bus16.out_result !== 32'd4294836224 || bus16.out_tag !== 4'hA) begin
            fails++;
            $display("FAIL w16_max: got v=%b res=%0d tag=%0d expected v=1 res=4294836224 tag=10",
                     bus16.out_valid, bus16.out_result, bus16.out_tag);
        end
        step();
    endtask

    task automatic test_random();
        localparam int N = 10000;
        longint     q_res [$];
        logic [3:0] q_tag [$];
        logic       q_zero [$];
        int         sent = 0;
        int         cyc = 0;
        longint     er;
        logic [3:0] et;
        logic       ez;
        while ((sent < N || q_res.size() != 0) && cyc < 60000) begin
            bus8.in_valid  = (sent < N) && ($urandom_range(0, 1) == 1);
            bus8.in_a      = 8'($urandom_range(0, 255));
            bus8.in_b      = 8'($urandom_range(0, 255));
            bus8.in_tag    = 4'(sent);
            bus8.out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (bus8.out_valid && bus8.out_ready) begin
                tests++;
                if (q_res.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra: got unexpected result %0d tag=%0d", bus8.out_result, bus8.out_tag);
                end else begin
                    er = q_res.pop_front();
                    et = q_tag.pop_front();
                    ez = q_zero.pop_front();
                    if (bus8.out_result !== 16'(er) || bus8.out_tag !== et || bus8.out_zero !== ez) begin
                        fails++;
                        $display("FAIL rnd_result: got res=%0d tag=%0d zero=%b expected res=%0d tag=%0d zero=%b",
                                 bus8.out_result, bus8.out_tag, bus8.out_zero, er, et, ez);
                    end
                end
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q_res.push_back(model(longint'(bus8.in_a), longint'(bus8.in_b), 8));
                q_tag.push_back(bus8.in_tag);
                q_zero.push_back(bus8.in_a == 8'd0 || bus8.in_b == 8'd0);
                sent++;
            end
            step();
            cyc++;
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        tests++;
        if (sent != N || q_res.size() != 0) begin
            fails++;
            $display("FAIL rnd_drain: got sent=%0d outstanding=%0d expected %0d/0", sent, q_res.size(), N);
        end
        step();
        step();
        step();
    endtask

    task automatic test_reset_midstall();
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.in_a      = 8'd3;
        bus8.in_b      = 8'd3;
        bus8.in_tag    = 4'd7;
        repeat (4) step();
        tests++;
        if (bus8.out_valid !== 1'b1 || bus8.busy !== 1'b1 || bus8.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_precond: got valid=%b busy=%b ready=%b expected 1/1/0",
                     bus8.out_valid, bus8.busy, bus8.in_ready);
        end
        bus8.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests++;
        if ({bus8.out_valid, bus8.busy, bus8.in_ready, bus8.out_zero} !== 4'b0010
            || bus8.out_result !== 16'd0 || bus8.out_tag !== 4'd0) begin
            fails++;
            $display("FAIL rst_midstall: got v/b/r/z=%b res=%0d tag=%0d expected 0010 res=0 tag=0",
                     {bus8.out_valid, bus8.busy, bus8.in_ready, bus8.out_zero}, bus8.out_result, bus8.out_tag);
        end
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.in_tag    = 4'd5;
        step();
        bus8.in_valid = 1'b0;
        step();
        step();
        tests++;
        if (bus8.out_valid !== 1'b1 || bus8.out_result !== 16'd8 || bus8.out_tag !== 4'd5) begin
            fails++;
            $display("FAIL rst_post_op: got v=%b res=%0d tag=%0d expected v=1 res=8 tag=5",
                     bus8.out_valid, bus8.out_result, bus8.out_tag);
        end
    endtask

    initial begin
        bus8.in_valid   = 1'b0;
        bus8.in_a       = '0;
        bus8.in_b       = '0;
        bus8.in_tag     = '0;
        bus8.out_ready  = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.in_a      = '0;
        bus16.in_b      = '0;
        bus16.in_tag    = '0;
        bus16.out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_width16();
        test_random();
        test_reset_midstall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
